// File: rtl/adder_sched_pkg.sv
// rtl/adder_sched_pkg.sv - shared types and helpers for the round-robin adder scheduler
package adder_sched_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } sched_state_e;

   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return r;
   endfunction

   function automatic int sum_w(input int width);
      return width + 2;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin winner search starting at ptr
module rr_arbiter
   import adder_sched_pkg::*;
#(
   parameter int N  = 4,
   parameter int IW = clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  gnt,
   output logic [IW-1:0] idx,
   output logic          any
);

   logic [IW-1:0] cand;
   logic          found;

   // N is a power of two, so the IW-bit add wraps the search naturally
   always_comb begin
      gnt   = '0;
      idx   = '0;
      cand  = '0;
      found = 1'b0;
      any   = |req;
      for (int k = 0; k < N; k++) begin
         cand = ptr + IW'(k);
         if (!found && req[cand]) begin
            found     = 1'b1;
            idx       = cand;
            gnt[cand] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/adder_rr_scheduler.sv
// rtl/adder_rr_scheduler.sv - round-robin sharing of one 4-operand adder between requesters
module adder_rr_scheduler
   import adder_sched_pkg::*;
#(
   parameter int WIDTH   = 4,
   parameter int NUM_REQ = 4,
   parameter int ADD_LAT = 1,
   parameter int ID_W    = clog2(NUM_REQ)
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [NUM_REQ-1:0]         req,
   input  logic [NUM_REQ*WIDTH-1:0]   op_a,
   input  logic [NUM_REQ*WIDTH-1:0]   op_b,
   input  logic [NUM_REQ*WIDTH-1:0]   op_c,
   input  logic [NUM_REQ*WIDTH-1:0]   op_d,
   output logic [NUM_REQ-1:0]         gnt,
   output logic [WIDTH-1:0]           add_a,
   output logic [WIDTH-1:0]           add_b,
   output logic [WIDTH-1:0]           add_c,
   output logic [WIDTH-1:0]           add_d,
   output logic                       add_valid,
   input  logic [sum_w(WIDTH)-1:0]    add_sum,
   output logic                       resp_valid,
   input  logic                       resp_ready,
   output logic [ID_W-1:0]            resp_id,
   output logic [sum_w(WIDTH)-1:0]    resp_sum,
   output logic                       busy
);

   localparam int CNT_W = (ADD_LAT > 1) ? clog2(ADD_LAT) : 1;

   sched_state_e     state, state_next;
   logic [ID_W-1:0]  ptr;
   logic [CNT_W-1:0] cnt;
   logic [NUM_REQ-1:0] arb_gnt;
   logic [ID_W-1:0]  arb_idx;
   logic             arb_any;
   logic             capture;

   rr_arbiter #(.N(NUM_REQ), .IW(ID_W)) u_arb (
      .req (req),
      .ptr (ptr),
      .gnt (arb_gnt),
      .idx (arb_idx),
      .any (arb_any)
   );

   assign add_valid  = (state == ISSUE);
   assign resp_valid = (state == RESP);
   assign busy       = (state != IDLE);
   // A combinational adder is sampled in the issue cycle itself
   assign capture    = ((state == ISSUE) && (ADD_LAT == 0)) ||
                       ((state == WAIT) && (cnt == '0));

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (arb_any) state_next = ISSUE;
         ISSUE:   state_next = (ADD_LAT == 0) ? RESP : WAIT;
         WAIT:    if (cnt == '0) state_next = RESP;
         RESP:    if (resp_ready) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         ptr      <= '0;
         cnt      <= '0;
         gnt      <= '0;
         add_a    <= '0;
         add_b    <= '0;
         add_c    <= '0;
         add_d    <= '0;
         resp_id  <= '0;
         resp_sum <= '0;
      end else begin
         state <= state_next;
         gnt   <= '0;
         if ((state == IDLE) && arb_any) begin
            gnt     <= arb_gnt;
            add_a   <= op_a[arb_idx*WIDTH +: WIDTH];
            add_b   <= op_b[arb_idx*WIDTH +: WIDTH];
            add_c   <= op_c[arb_idx*WIDTH +: WIDTH];
            add_d   <= op_d[arb_idx*WIDTH +: WIDTH];
            resp_id <= arb_idx;
            ptr     <= arb_idx + ID_W'(1);
         end
         if (state == ISSUE)
            cnt <= CNT_W'((ADD_LAT > 0) ? ADD_LAT - 1 : 0);
         else if (state == WAIT)
            cnt <= cnt - CNT_W'(1);
         if (capture)
            resp_sum <= add_sum;
      end
   end

endmodule

// File: tb/tb_adder_rr_scheduler.sv
// tb/tb_adder_rr_scheduler.sv - directed scoreboard bench for adder_rr_scheduler at latencies 0, 1 and 3
module tb_adder_rr_scheduler;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic [15:0] op_a, op_b, op_c, op_d;
   logic [3:0]  req_v [3];
   logic        resp_ready_v [3];
   logic [3:0]  gnt_v [3];
   logic [3:0]  aa [3], ab [3], ac [3], ad [3];
   logic        av [3];
   logic [5:0]  add_sum_v [3];
   logic        rv [3];
   logic [1:0]  rid [3];
   logic [5:0]  rsum [3];
   logic        busy_v [3];

   // index 0: ADD_LAT=0, index 1: ADD_LAT=1, index 2: ADD_LAT=3
   adder_rr_scheduler #(.WIDTH(4), .NUM_REQ(4), .ADD_LAT(0)) u_lat0 (
      .clk(clk), .rst(rst), .req(req_v[0]), .op_a(op_a), .op_b(op_b), .op_c(op_c), .op_d(op_d),
      .gnt(gnt_v[0]), .add_a(aa[0]), .add_b(ab[0]), .add_c(ac[0]), .add_d(ad[0]),
      .add_valid(av[0]), .add_sum(add_sum_v[0]), .resp_valid(rv[0]), .resp_ready(resp_ready_v[0]),
      .resp_id(rid[0]), .resp_sum(rsum[0]), .busy(busy_v[0]));

   adder_rr_scheduler #(.WIDTH(4), .NUM_REQ(4), .ADD_LAT(1)) u_lat1 (
      .clk(clk), .rst(rst), .req(req_v[1]), .op_a(op_a), .op_b(op_b), .op_c(op_c), .op_d(op_d),
      .gnt(gnt_v[1]), .add_a(aa[1]), .add_b(ab[1]), .add_c(ac[1]), .add_d(ad[1]),
      .add_valid(av[1]), .add_sum(add_sum_v[1]), .resp_valid(rv[1]), .resp_ready(resp_ready_v[1]),
      .resp_id(rid[1]), .resp_sum(rsum[1]), .busy(busy_v[1]));

   adder_rr_scheduler #(.WIDTH(4), .NUM_REQ(4), .ADD_LAT(3)) u_lat3 (
      .clk(clk), .rst(rst), .req(req_v[2]), .op_a(op_a), .op_b(op_b), .op_c(op_c), .op_d(op_d),
      .gnt(gnt_v[2]), .add_a(aa[2]), .add_b(ab[2]), .add_c(ac[2]), .add_d(ad[2]),
      .add_valid(av[2]), .add_sum(add_sum_v[2]), .resp_valid(rv[2]), .resp_ready(resp_ready_v[2]),
      .resp_id(rid[2]), .resp_sum(rsum[2]), .busy(busy_v[2]));

   function automatic logic [5:0] sum4(input logic [3:0] a, b, c, d);
      return 6'(a) + 6'(b) + 6'(c) + 6'(d);
   endfunction

   logic [5:0] s1, p0, p1, p2;
   always_ff @(posedge clk) begin
      s1 <= sum4(aa[1], ab[1], ac[1], ad[1]);
      p0 <= sum4(aa[2], ab[2], ac[2], ad[2]);
      p1 <= p0;
      p2 <= p1;
   end
   assign add_sum_v[0] = sum4(aa[0], ab[0], ac[0], ad[0]);
   assign add_sum_v[1] = s1;
   assign add_sum_v[2] = p2;

   int checks = 0;
   int errors = 0;

   typedef struct {
      int id;
      int sum;
   } exp_t;
   exp_t sb [$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic set_ops(input int i, input int a, input int b, input int c, input int d);
      op_a[i*4 +: 4] = 4'(a);
      op_b[i*4 +: 4] = 4'(b);
      op_c[i*4 +: 4] = 4'(c);
      op_d[i*4 +: 4] = 4'(d);
   endtask

   task automatic push_exp(input int id);
      exp_t e;
      e.id  = id;
      e.sum = int'(op_a[id*4 +: 4]) + int'(op_b[id*4 +: 4]) +
              int'(op_c[id*4 +: 4]) + int'(op_d[id*4 +: 4]);
      sb.push_back(e);
   endtask

   // One full transaction on instance k: grant, latency, response, optional backpressure, accept
   task automatic txn(input string tag, input int k, input int lat, input logic [3:0] r,
                      input int exp_id, input int hold, input bit keep);
      exp_t e;
      req_v[k]        = r;
      resp_ready_v[k] = (hold == 0);
      push_exp(exp_id);
      tick;
      check({tag, " gnt"}, 32'(gnt_v[k]), 32'(1 << exp_id));
      check({tag, " add_valid"}, 32'(av[k]), 32'd1);
      check({tag, " busy"}, 32'(busy_v[k]), 32'd1);
      if (!keep) req_v[k] = 4'b0000;
      for (int j = 0; j < lat; j++) begin
         tick;
         check({tag, " early resp_valid"}, 32'(rv[k]), 32'd0);
         check({tag, " gnt after issue"}, 32'(gnt_v[k]), 32'd0);
      end
      tick;
      check({tag, " resp_valid"}, 32'(rv[k]), 32'd1);
      e = sb.pop_front();
      check({tag, " resp_id"}, 32'(rid[k]), 32'(e.id));
      check({tag, " resp_sum"}, 32'(rsum[k]), 32'(e.sum));
      for (int h = 0; h < hold; h++) begin
         tick;
         check({tag, " held resp_valid"}, 32'(rv[k]), 32'd1);
         check({tag, " held resp_sum"}, 32'(rsum[k]), 32'(e.sum));
         check({tag, " held resp_id"}, 32'(rid[k]), 32'(e.id));
         check({tag, " no gnt in resp"}, 32'(gnt_v[k]), 32'd0);
      end
      resp_ready_v[k] = 1'b1;
      tick;
      check({tag, " resp_valid drop"}, 32'(rv[k]), 32'd0);
      check({tag, " busy drop"}, 32'(busy_v[k]), 32'd0);
   endtask

   int rr_seq_a [5] = '{0, 1, 2, 3, 0};
   int rr_seq_b [4] = '{1, 3, 1, 3};

   initial begin
      rst  = 1'b1;
      op_a = '0; op_b = '0; op_c = '0; op_d = '0;
      for (int k = 0; k < 3; k++) begin
         req_v[k]        = 4'b0000;
         resp_ready_v[k] = 1'b0;
      end
      req_v[1] = 4'b1111;

      for (int i = 0; i < 3; i++) begin
         tick;
         check("reset gnt", 32'(gnt_v[1]), 32'd0);
         check("reset add_valid", 32'(av[1]), 32'd0);
         check("reset resp_valid", 32'(rv[1]), 32'd0);
         check("reset busy", 32'(busy_v[1]), 32'd0);
      end
      check("reset resp_id", 32'(rid[1]), 32'd0);
      check("reset resp_sum", 32'(rsum[1]), 32'd0);
      check("reset add_a", 32'(aa[1]), 32'd0);
      rst = 1'b0;
      txn("first_after_reset", 1, 1, 4'b1111, 0, 0, 1'b0);

      set_ops(2, 15, 15, 15, 15);
      txn("single", 1, 1, 4'b0100, 2, 0, 1'b0);
      check("single sum 60", 32'(rsum[1]), 32'd60);

      rst = 1'b1;
      tick;
      rst = 1'b0;
      for (int i = 0; i < 4; i++) set_ops(i, i + 1, i + 2, i + 3, i + 4);
      for (int i = 0; i < 5; i++) txn("rr_all", 1, 1, 4'b1111, rr_seq_a[i], 0, 1'b1);
      for (int i = 0; i < 4; i++) txn("rr_1010", 1, 1, 4'b1010, rr_seq_b[i], 0, 1'b1);
      req_v[1] = 4'b0000;

      set_ops(1, 1, 2, 3, 4);
      txn("backpressure", 1, 1, 4'b0010, 1, 5, 1'b0);
      check("backpressure sum 10", 32'(rsum[1]), 32'd10);

      set_ops(0, 7, 0, 9, 1);
      txn("lat0", 0, 0, 4'b0001, 0, 0, 1'b0);
      check("lat0 sum 17", 32'(rsum[0]), 32'd17);
      txn("lat3", 2, 3, 4'b0001, 0, 0, 1'b0);
      check("lat3 sum 17", 32'(rsum[2]), 32'd17);

      req_v[2] = 4'b1000;
      tick;
      check("abort gnt", 32'(gnt_v[2]), 32'b1000);
      req_v[2] = 4'b0000;
      tick;
      tick;
      check("abort in wait busy", 32'(busy_v[2]), 32'd1);
      rst = 1'b1;
      tick;
      rst = 1'b0;
      check("abort busy", 32'(busy_v[2]), 32'd0);
      check("abort resp_valid", 32'(rv[2]), 32'd0);
      for (int i = 0; i < 6; i++) begin
         tick;
         check("abort no resp", 32'(rv[2]), 32'd0);
      end
      txn("after_abort", 2, 3, 4'b1111, 0, 0, 1'b0);

      check("scoreboard empty", 32'(sb.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
